// File: rtl/lcd_ctrl.sv
// lcd_ctrl - turns one 32-bit LCD register store into a single HD44780-style
// 8-bit bus write with setup, enable-pulse and execution timing, so software
// only writes a word and polls busy.
//
// Ports
//   i_clk       system clock
//   i_reset     asynchronous reset, active-low
//   i_lcd_wr    one-cycle strobe: store to the LCD register
//   i_lcd_word  [31]=ON, [9]=RS, [7:0]=DATA; other bits ignored
//   o_lcd_busy  1 while a command or the power-up wait is in progress
//   o_lcd_ovf   sticky: a strobe arrived while not idle (cleared by reset only)
//   o_lcd_on    panel power/backlight, updated by every strobe
//   o_lcd_en    LCD enable pulse
//   o_lcd_rs    register select, 0=command 1=data
//   o_lcd_rw    always 0 (write-only bus)
//   o_lcd_data  LCD data bus
module lcd_ctrl #(
   parameter int unsigned SETUP_CYC = 3,
   parameter int unsigned EN_CYC    = 12,
   parameter int unsigned EXEC_CYC  = 2000,
   parameter int unsigned LONG_CYC  = 82000,
   parameter int unsigned PWRUP_CYC = 750000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_lcd_wr,
   input  logic [31:0] i_lcd_word,
   output logic        o_lcd_busy,
   output logic        o_lcd_ovf,
   output logic        o_lcd_on,
   output logic        o_lcd_en,
   output logic        o_lcd_rs,
   output logic        o_lcd_rw,
   output logic [7:0]  o_lcd_data
);

   localparam int unsigned MAX_AB  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
   localparam int unsigned MAX_CD  = (EXEC_CYC > LONG_CYC) ? EXEC_CYC : LONG_CYC;
   localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int unsigned MAX_CYC = (MAX_ABCD > PWRUP_CYC) ? MAX_ABCD : PWRUP_CYC;
   localparam int          CW      = $clog2(MAX_CYC) + 1;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          is_long;

   // Word bits outside ON/RS/DATA carry no meaning for this block.
   logic unused_word_bits;
   assign unused_word_bits = ^{i_lcd_word[30:10], i_lcd_word[8]};

   // Clear display (0x01) and return home (0x02/0x03) need the long
   // execution wait; decided from the latched command, not the live bus.
   assign is_long = !o_lcd_rs &&
                    (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 || o_lcd_data == 8'h03);

   // Each state is entered with cnt = duration-1 and leaves on the edge where
   // cnt is already 0, so a state lasts exactly its parameter in cycles.
   // NOTE: all state and outputs update with non-blocking assignments so every
   // branch sees the pre-edge values of state, cnt and the latched RS/DATA.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state      <= ST_PWRUP;
         cnt        <= CW'(PWRUP_CYC - 1);
         o_lcd_busy <= 1'b1;
         o_lcd_ovf  <= 1'b0;
         o_lcd_on   <= 1'b0;
         o_lcd_en   <= 1'b0;
         o_lcd_rs   <= 1'b0;
         o_lcd_rw   <= 1'b0;
         o_lcd_data <= 8'h00;
      end else begin
         o_lcd_rw <= 1'b0;

         // Power control follows every strobe, even those that are dropped.
         if (i_lcd_wr) begin
            o_lcd_on <= i_lcd_word[31];
            if (state != ST_IDLE) o_lcd_ovf <= 1'b1;
         end

         case (state)
            ST_PWRUP: begin
               if (cnt == '0) begin
                  state      <= ST_IDLE;
                  o_lcd_busy <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_IDLE: begin
               if (i_lcd_wr) begin
                  o_lcd_rs   <= i_lcd_word[9];
                  o_lcd_data <= i_lcd_word[7:0];
                  o_lcd_busy <= 1'b1;
                  state      <= ST_SETUP;
                  cnt        <= CW'(SETUP_CYC - 1);
               end
            end

            ST_SETUP: begin
               if (cnt == '0) begin
                  state    <= ST_PULSE;
                  o_lcd_en <= 1'b1;
                  cnt      <= CW'(EN_CYC - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_PULSE: begin
               if (cnt == '0) begin
                  state    <= ST_WAIT;
                  o_lcd_en <= 1'b0;
                  cnt      <= is_long ? CW'(LONG_CYC - 1) : CW'(EXEC_CYC - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            ST_WAIT: begin
               if (cnt == '0) begin
                  state      <= ST_IDLE;
                  o_lcd_busy <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            default: begin
               state      <= ST_PWRUP;
               cnt        <= CW'(PWRUP_CYC - 1);
               o_lcd_busy <= 1'b1;
               o_lcd_en   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl - self-checking bench for lcd_ctrl. The reference model keeps
// absolute edge timestamps (when busy ends, when EN starts/ends) instead of
// states, and every cycle the DUT outputs are compared against it.
module tb_lcd_ctrl;

   localparam int SETUP = 2;
   localparam int EN    = 3;
   localparam int EXEC  = 5;
   localparam int LONG  = 20;
   localparam int PWRUP = 10;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_lcd_wr;
   logic [31:0] i_lcd_word;
   logic        o_lcd_busy;
   logic        o_lcd_ovf;
   logic        o_lcd_on;
   logic        o_lcd_en;
   logic        o_lcd_rs;
   logic        o_lcd_rw;
   logic [7:0]  o_lcd_data;

   lcd_ctrl #(
      .SETUP_CYC (SETUP),
      .EN_CYC    (EN),
      .EXEC_CYC  (EXEC),
      .LONG_CYC  (LONG),
      .PWRUP_CYC (PWRUP)
   ) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_lcd_wr   (i_lcd_wr),
      .i_lcd_word (i_lcd_word),
      .o_lcd_busy (o_lcd_busy),
      .o_lcd_ovf  (o_lcd_ovf),
      .o_lcd_on   (o_lcd_on),
      .o_lcd_en   (o_lcd_en),
      .o_lcd_rs   (o_lcd_rs),
      .o_lcd_rw   (o_lcd_rw),
      .o_lcd_data (o_lcd_data)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: n counts rising edges since reset release.
   bit       in_reset;
   int       n;
   int       free_at;   // busy is 1 after edge m while m < free_at
   int       en_start;  // EN is 1 after edge m for en_start <= m < en_end
   int       en_end;
   bit       m_on;
   bit       m_ovf;
   bit       m_rs;
   bit [7:0] m_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit wr, input logic [31:0] word);
      int wait_len;
      if (in_reset) return;
      n++;
      if (wr) begin
         m_on = word[31];
         // Idle before edge n means busy was already 0 after edge n-1.
         if (n > free_at) begin
            m_rs     = word[9];
            m_data   = word[7:0];
            wait_len = (!m_rs && m_data >= 8'd1 && m_data <= 8'd3) ? LONG : EXEC;
            en_start = n + SETUP;
            en_end   = en_start + EN;
            free_at  = en_end + wait_len;
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare();
      bit exp_busy;
      bit exp_en;
      exp_busy = in_reset || (n < free_at);
      exp_en   = !in_reset && (n >= en_start) && (n < en_end);
      check("busy", 32'(o_lcd_busy), 32'(exp_busy));
      check("en",   32'(o_lcd_en),   32'(exp_en));
      check("ovf",  32'(o_lcd_ovf),  32'(m_ovf));
      check("on",   32'(o_lcd_on),   32'(m_on));
      check("rs",   32'(o_lcd_rs),   32'(m_rs));
      check("rw",   32'(o_lcd_rw),   32'(1'b0));
      check("data", 32'(o_lcd_data), 32'(m_data));
   endtask

   // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
   task automatic step(input bit wr, input logic [31:0] word);
      i_lcd_wr   = wr;
      i_lcd_word = word;
      @(posedge i_clk);
      model_edge(wr, word);
      @(negedge i_clk);
      i_lcd_wr   = 1'b0;
      i_lcd_word = 32'h0;
      compare();
   endtask

   task automatic assert_reset();
      i_reset  = 1'b0;
      in_reset = 1'b1;
      m_on     = 1'b0;
      m_ovf    = 1'b0;
      m_rs     = 1'b0;
      m_data   = 8'h00;
      #1 compare();
   endtask

   task automatic release_reset();
      i_reset  = 1'b1;
      in_reset = 1'b0;
      n        = 0;
      free_at  = PWRUP;
      en_start = -1000;
      en_end   = -1000;
      #1 compare();
   endtask

   task automatic wait_idle(input string name);
      int i;
      for (i = 0; i < 200 && o_lcd_busy; i++) step(1'b0, 32'h0);
      if (i == 200) check({name, "_timeout"}, 32'(o_lcd_busy), 32'(1'b0));
   endtask

   // Issue one strobe and measure, in cycles after the accept edge (cycle 1
   // follows the accept edge), how long busy and EN stay high.
   task automatic measure(input logic [31:0] word, output int busy_cyc,
                          output int en_cyc, output int en_first);
      busy_cyc = 0;
      en_cyc   = 0;
      en_first = 0;
      step(1'b1, word);
      for (int i = 1; i <= 200; i++) begin
         if (i > 1) step(1'b0, 32'h0);
         if (!o_lcd_busy) break;
         busy_cyc++;
         if (o_lcd_en) begin
            en_cyc++;
            if (en_first == 0) en_first = i;
         end
      end
   endtask

   initial begin
      int busy_cyc;
      int en_cyc;
      int en_first;
      int en_seen;
      logic [31:0] word;
      bit wr;

      i_lcd_wr   = 1'b0;
      i_lcd_word = 32'h0;
      @(negedge i_clk);
      assert_reset();
      repeat (2) step(1'b0, 32'h0);
      check("rst_busy_lit", 32'(o_lcd_busy), 32'd1);
      release_reset();

      // Power-up wait.
      repeat (PWRUP - 1) step(1'b0, 32'h0);
      check("pwrup_busy_lit", 32'(o_lcd_busy), 32'd1);
      step(1'b0, 32'h0);
      check("pwrup_done_lit", 32'(o_lcd_busy), 32'd0);

      // Data write 'A' with power on.
      measure(32'h8000_0241, busy_cyc, en_cyc, en_first);
      check("data_busy_len", 32'(busy_cyc), 32'd10);
      check("data_en_len",   32'(en_cyc),   32'd3);
      check("data_en_first", 32'(en_first), 32'd3);
      check("data_on_lit",   32'(o_lcd_on),   32'd1);
      check("data_rs_lit",   32'(o_lcd_rs),   32'd1);
      check("data_val_lit",  32'(o_lcd_data), 32'h41);

      // Clear display uses the long wait; function set uses the normal one.
      measure(32'h0000_0001, busy_cyc, en_cyc, en_first);
      check("clear_busy_len", 32'(busy_cyc), 32'd25);
      check("clear_on_lit",   32'(o_lcd_on), 32'd0);
      measure(32'h0000_0038, busy_cyc, en_cyc, en_first);
      check("fset_busy_len", 32'(busy_cyc), 32'd10);
      check("ovf_clear_lit", 32'(o_lcd_ovf), 32'd0);

      // Strobe four cycles after an accept is dropped and sets ovf.
      step(1'b1, 32'h0000_0028);
      repeat (3) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_0255);
      check("drop_ovf_lit",  32'(o_lcd_ovf),  32'd1);
      check("drop_data_lit", 32'(o_lcd_data), 32'h28);
      check("drop_rs_lit",   32'(o_lcd_rs),   32'd0);
      wait_idle("drop");
      measure(32'h0000_020C, busy_cyc, en_cyc, en_first);
      check("ovf_sticky_lit", 32'(o_lcd_ovf), 32'd1);

      // Back-to-back strobes on an idle controller.
      step(1'b1, 32'h0000_0206);
      step(1'b1, 32'h0000_0207);
      check("b2b_data_lit", 32'(o_lcd_data), 32'h06);
      wait_idle("b2b");

      // Strobe during power-up: on/ovf update, no bus cycle.
      assert_reset();
      step(1'b0, 32'h0);
      release_reset();
      step(1'b0, 32'h0);
      step(1'b1, 32'h8000_0241);
      check("pwrup_on_lit",  32'(o_lcd_on),  32'd1);
      check("pwrup_ovf_lit", 32'(o_lcd_ovf), 32'd1);
      en_seen = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 32'h0);
         if (o_lcd_en) en_seen++;
      end
      check("pwrup_no_en", 32'(en_seen), 32'd0);
      check("pwrup_data_lit", 32'(o_lcd_data), 32'h00);

      // Reset asserted while EN is high aborts at once and repeats power-up.
      wait_idle("pre_abort");
      step(1'b1, 32'h8000_0248);
      for (int i = 0; i < 20 && !o_lcd_en; i++) step(1'b0, 32'h0);
      check("abort_en_before", 32'(o_lcd_en), 32'd1);
      assert_reset();
      check("abort_en_lit",   32'(o_lcd_en),   32'd0);
      check("abort_busy_lit", 32'(o_lcd_busy), 32'd1);
      check("abort_on_lit",   32'(o_lcd_on),   32'd0);
      step(1'b0, 32'h0);
      release_reset();
      repeat (PWRUP - 1) step(1'b0, 32'h0);
      check("abort_pwrup_lit", 32'(o_lcd_busy), 32'd1);
      step(1'b0, 32'h0);
      check("abort_pwrup_done", 32'(o_lcd_busy), 32'd0);

      // Randomized traffic, with clear/home commands made common.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            assert_reset();
            repeat ($urandom_range(1, 3)) step(1'b0, 32'h0);
            release_reset();
         end else begin
            wr   = ($urandom_range(0, 5) == 0);
            word = $urandom;
            if ($urandom_range(0, 3) == 0) begin
               word[9]   = 1'b0;
               word[7:0] = 8'($urandom_range(1, 3));
            end
            step(wr, word);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
